// File: rtl/int_layer2_mac_seq_pkg.sv
// int_mlp_pkg: shared sizes, sequencer states and weight-lane extraction for the layer-2 MAC
package int_mlp_pkg;
  localparam int N_IN = 32;
  localparam int N_OUT = 10;
  localparam int W_W = 16;
  localparam int A_W = 16;
  localparam int ACC_W = 40;
  localparam int ADDR_W = 7;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, ARGMAX, DONE} state_t;
  function automatic logic signed [W_W-1:0] w_lane(input logic [N_OUT*W_W-1:0] w, input int j);
    return w[(N_OUT-j)*W_W-1 -: W_W];
  endfunction
endpackage

// File: rtl/int_layer2_mac_seq_if.sv
// int_layer2_mac_seq_if: start/busy, activation stream, ROM port and result handshake
interface int_layer2_mac_seq_if;
  import int_mlp_pkg::*;
  logic start;
  logic busy;
  logic act_valid;
  logic act_ready;
  logic signed [A_W-1:0] act_data;
  logic [ADDR_W-1:0] w_addr;
  logic [N_OUT*W_W-1:0] w_data;
  logic res_valid;
  logic res_ready;
  logic [N_OUT*ACC_W-1:0] res_logits;
  logic [3:0] res_class;
  modport master(output start, act_valid, act_data, w_data, res_ready,
                 input busy, act_ready, w_addr, res_valid, res_logits, res_class);
  modport slave(input start, act_valid, act_data, w_data, res_ready,
                output busy, act_ready, w_addr, res_valid, res_logits, res_class);
endinterface

// File: rtl/int_layer2_mac_seq_argmax.sv
// int_argmax_seq: sequential argmax over packed logits, lane 0 on start then lanes 1..N_OUT-1, ties keep lowest index
module int_argmax_seq
  import int_mlp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_OUT*ACC_W-1:0] logits,
  output logic                   done,
  output logic [3:0]             cls
);
  logic run;
  logic [3:0] idx;
  logic signed [ACC_W-1:0] best, cand;
  assign cand = logits[(N_OUT-int'(idx))*ACC_W-1 -: ACC_W];
  assign done = run && idx == 4'(N_OUT-1);
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      idx <= '0;
      best <= '0;
      cls <= '0;
    end else if (start) begin
      run <= 1'b1;
      idx <= 4'd1;
      best <= logits[N_OUT*ACC_W-1 -: ACC_W];
      cls <= '0;
    end else if (run) begin
      if (cand > best) begin
        best <= cand;
        cls <= idx;
      end
      run <= !done;
      idx <= done ? idx : idx + 4'd1;
    end
  end
endmodule

// File: rtl/int_layer2_mac_seq.sv
// int_layer2_mac_seq: streams 32 activations against ROM weight rows, accumulates 10 logits, then argmax
module int_layer2_mac_seq
  import int_mlp_pkg::*;
(
  input logic clk,
  input logic rst,
  int_layer2_mac_seq_if.slave bus
);
  state_t state;
  logic [ADDR_W-1:0] k;
  logic signed [A_W-1:0] act_reg;
  logic s1v, arg_start, arg_done, accept;
  logic signed [ACC_W-1:0] acc [N_OUT];
  logic signed [2*W_W-1:0] prod [N_OUT];
  logic [N_OUT*ACC_W-1:0] logits;
  assign accept = bus.act_valid && bus.act_ready;
  assign bus.w_addr = k;
  assign bus.res_logits = logits;
  always_comb begin
    logits = '0;
    for (int j = 0; j < N_OUT; j++) begin
      prod[j] = w_lane(bus.w_data, j) * act_reg;
      logits[(N_OUT-j)*ACC_W-1 -: ACC_W] = acc[j];
    end
  end
  int_argmax_seq u_argmax (
    .clk(clk),
    .rst(rst),
    .start(arg_start),
    .logits(logits),
    .done(arg_done),
    .cls(bus.res_class)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      act_reg <= '0;
      s1v <= 1'b0;
      arg_start <= 1'b0;
      bus.busy <= 1'b0;
      bus.act_ready <= 1'b0;
      bus.res_valid <= 1'b0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else begin
      s1v <= accept;
      arg_start <= 1'b0;
      if (accept) begin
        act_reg <= bus.act_data;
        k <= k == ADDR_W'(N_IN-1) ? '0 : k + 1'b1;
      end
      if (s1v) for (int j = 0; j < N_OUT; j++) acc[j] <= acc[j] + ACC_W'(prod[j]);
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          bus.busy <= 1'b1;
          bus.act_ready <= 1'b1;
          k <= '0;
          for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
        end
        RUN: if (accept && k == ADDR_W'(N_IN-1)) begin
          state <= DRAIN;
          bus.act_ready <= 1'b0;
        end
        DRAIN: begin
          state <= ARGMAX;
          arg_start <= 1'b1;
        end
        ARGMAX: if (arg_done) begin
          state <= DONE;
          bus.res_valid <= 1'b1;
        end
        DONE: if (bus.res_ready) begin
          state <= IDLE;
          bus.res_valid <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
